// File: rtl/seven_seg_reader.sv
// seven_seg_reader: stability-filters a multiplexed active-low 7-seg bus, decodes glyphs, assembles hex frames.
// Define SEG_ALT_GLYPH_EN to also accept the alternate 7 (with f) and 9 (without d) glyphs.
module seven_seg_reader #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg,
   input  logic [2:0]              dig_sel,
   input  logic                    seg_strb,
   output logic [4*NUM_DIGITS-1:0] hex_out,
   output logic                    out_valid,
   output logic                    bad_seg,
   output logic                    seq_err
);
   localparam logic [7:0] ACC_CNT = 8'(STABLE_CYCLES - 1);
   localparam logic [2:0] LAST    = 3'(NUM_DIGITS - 1);
   typedef enum logic {IDLE, FILL} state_t;
   state_t                  state;
   logic [6:0]              sh_seg;
   logic [2:0]              sh_sel;
   logic [7:0]              cnt;
   logic [2:0]              exp_pos;
   logic [4*NUM_DIGITS-1:0] fb, fb_next;
   logic                    match, accept, legal;
   logic [3:0]              nib;
   // cnt=0 means no run in progress, so even an identical sample starts a new run
   assign match  = ({seg, dig_sel} == {sh_seg, sh_sel}) && cnt != 8'd0;
   assign accept = seg_strb && match && cnt == ACC_CNT;
   always_comb begin
      legal = 1'b1;
      nib   = 4'h0;
      case (seg)
         7'b1000000: nib = 4'h0;
         7'b1111001: nib = 4'h1;
         7'b0100100: nib = 4'h2;
         7'b0110000: nib = 4'h3;
         7'b0011001: nib = 4'h4;
         7'b0010010: nib = 4'h5;
         7'b0000010: nib = 4'h6;
         7'b1111000: nib = 4'h7;
         7'b0000000: nib = 4'h8;
         7'b0010000: nib = 4'h9;
         7'b0001000: nib = 4'ha;
         7'b0000011: nib = 4'hb;
         7'b1000110: nib = 4'hc;
         7'b0100001: nib = 4'hd;
         7'b0000110: nib = 4'he;
         7'b0001110: nib = 4'hf;
`ifdef SEG_ALT_GLYPH_EN
         7'b1011000: nib = 4'h7;
         7'b0011000: nib = 4'h9;
`endif
         default:    legal = 1'b0;
      endcase
   end
   always_comb begin
      fb_next = fb;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (exp_pos == 3'(i)) fb_next[4*i +: 4] = nib;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sh_seg    <= '0;
         sh_sel    <= '0;
         cnt       <= '0;
         exp_pos   <= '0;
         fb        <= '0;
         hex_out   <= '0;
         out_valid <= 1'b0;
         bad_seg   <= 1'b0;
         seq_err   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         bad_seg   <= 1'b0;
         seq_err   <= 1'b0;
         if (!seg_strb) cnt <= '0;
         else if (!match) begin
            sh_seg <= seg;
            sh_sel <= dig_sel;
            cnt    <= 8'd1;
         end else if (cnt != 8'hff) cnt <= cnt + 8'd1;
         if (accept) begin
            if (!legal) begin
               bad_seg <= 1'b1;
               state   <= IDLE;
               exp_pos <= '0;
            end else if (dig_sel == exp_pos) begin
               fb <= fb_next;
               if (exp_pos == LAST) begin
                  hex_out   <= fb_next;
                  out_valid <= 1'b1;
                  state     <= IDLE;
                  exp_pos   <= '0;
               end else begin
                  exp_pos <= exp_pos + 3'd1;
                  state   <= FILL;
               end
            end else if (dig_sel == 3'd0) begin
               fb[3:0] <= nib;
               exp_pos <= 3'd1;
               seq_err <= state == FILL;
               state   <= FILL;
            end else begin
               seq_err <= 1'b1;
               state   <= IDLE;
               exp_pos <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_seven_seg_reader.sv
// tb_seven_seg_reader: directed and random stimulus checked every cycle against a queue-based frame model.
module tb_seven_seg_reader;
   localparam int ND = 4, SC = 4;
   logic        clk = 1'b0, rst_n = 1'b0, seg_strb = 1'b0;
   logic [6:0]  seg = '0;
   logic [2:0]  dig_sel = '0;
   logic [15:0] hex_out;
   logic        out_valid, bad_seg, seq_err;
   int          total = 0, bad = 0, n_ov = 0, n_bad = 0, n_seq = 0;
   logic [6:0]  glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   logic [6:0]  m_seg;
   logic [2:0]  m_sel;
   int          m_run;
   int          digs[$];
   logic [15:0] m_hex;
   logic        m_ov, m_bad, m_seq;

   seven_seg_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel), .seg_strb(seg_strb),
      .hex_out(hex_out), .out_valid(out_valid), .bad_seg(bad_seg), .seq_err(seq_err));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic int lookup(logic [6:0] s);
      for (int i = 0; i < 16; i++) if (glyph[i] == s) return i;
`ifdef SEG_ALT_GLYPH_EN
      if (s == 7'b1011000) return 7;
      if (s == 7'b0011000) return 9;
`endif
      return -1;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic model_reset();
      m_run = 0;
      digs.delete();
      m_hex = '0;
      m_ov = 1'b0;
      m_bad = 1'b0;
      m_seq = 1'b0;
   endtask

   task automatic model_step();
      int d;
      m_ov = 1'b0;
      m_bad = 1'b0;
      m_seq = 1'b0;
      if (!seg_strb) m_run = 0;
      else if (m_run > 0 && seg == m_seg && dig_sel == m_sel) m_run++;
      else begin
         m_seg = seg;
         m_sel = dig_sel;
         m_run = 1;
      end
      if (seg_strb && m_run == SC) begin
         d = lookup(seg);
         if (d < 0) begin
            m_bad = 1'b1;
            digs.delete();
         end else if (int'(dig_sel) == digs.size()) begin
            digs.push_back(d);
            if (digs.size() == ND) begin
               m_hex = '0;
               foreach (digs[i]) m_hex = m_hex | (16'(digs[i]) << (4 * i));
               m_ov = 1'b1;
               digs.delete();
            end
         end else if (dig_sel == 3'd0) begin
            m_seq = digs.size() > 0;
            digs.delete();
            digs.push_back(d);
         end else begin
            m_seq = 1'b1;
            digs.delete();
         end
      end
   endtask

   task automatic cycle(logic [6:0] s, logic [2:0] sel, logic strb);
      seg = s;
      dig_sel = sel;
      seg_strb = strb;
      model_step();
      @(posedge clk);
      #1;
      chk("hex_out", hex_out, m_hex);
      chk("out_valid", out_valid, m_ov);
      chk("bad_seg", bad_seg, m_bad);
      chk("seq_err", seq_err, m_seq);
      n_ov += int'(out_valid);
      n_bad += int'(bad_seg);
      n_seq += int'(seq_err);
   endtask

   task automatic hold(logic [6:0] s, logic [2:0] sel, int n);
      repeat (n) cycle(s, sel, 1'b1);
   endtask

   task automatic idle(int n);
      repeat (n) cycle(7'h00, 3'd0, 1'b0);
   endtask

   initial begin
      int o, b, q, k, len;
      logic [6:0] s;
      logic [2:0] sel;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hex", hex_out, 16'h0);
      chk("reset_ov", out_valid, 1'b0);
      chk("reset_bad", bad_seg, 1'b0);
      chk("reset_seq", seq_err, 1'b0);
      rst_n = 1'b1;
      idle(2);
      // frame 1,2,3,4: pulse on the 4th sample of the last digit
      o = n_ov;
      hold(glyph[1], 3'd0, 6);
      hold(glyph[2], 3'd1, 6);
      hold(glyph[3], 3'd2, 6);
      hold(glyph[4], 3'd3, 3);
      chk("frame_early", n_ov - o, 0);
      hold(glyph[4], 3'd3, 1);
      chk("frame_pulse_now", out_valid, 1'b1);
      hold(glyph[4], 3'd3, 2);
      chk("frame_pulses", n_ov - o, 1);
      chk("frame_hex", hex_out, 16'h4321);
      // glitch: a 3-sample run is never accepted
      hold(glyph[1], 3'd0, 3);
      hold(glyph[0], 3'd0, 4);
      hold(glyph[1], 3'd1, 4);
      hold(glyph[2], 3'd2, 4);
      hold(glyph[3], 3'd3, 4);
      chk("glitch_hex", hex_out, 16'h3210);
      // illegal pattern
      b = n_bad;
      o = n_ov;
      hold(7'h7f, 3'd0, 4);
      chk("illegal_bad", n_bad - b, 1);
      chk("illegal_ov", n_ov - o, 0);
      for (int i = 0; i < 4; i++) hold(glyph[8], 3'(i), 4);
      chk("illegal_next_hex", hex_out, 16'h8888);
      // out-of-order digit
      q = n_seq;
      hold(glyph[5], 3'd0, 4);
      hold(glyph[5], 3'd2, 4);
      chk("order_seq", n_seq - q, 1);
      chk("order_hex", hex_out, 16'h8888);
      idle(1);
      // alternate glyph
      b = n_bad;
      hold(7'b0011000, 3'd0, 4);
`ifdef SEG_ALT_GLYPH_EN
      for (int i = 1; i < 4; i++) hold(7'b0011000, 3'(i), 4);
      chk("alt_hex", hex_out, 16'h9999);
      chk("alt_bad", n_bad - b, 0);
`else
      chk("alt_bad", n_bad - b, 1);
`endif
      // async reset mid-frame
      hold(glyph[7], 3'd0, 4);
      hold(glyph[7], 3'd1, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_hex", hex_out, 16'h0);
      chk("areset_ov", out_valid, 1'b0);
      chk("areset_bad", bad_seg, 1'b0);
      chk("areset_seq", seq_err, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      hold(glyph[7], 3'd1, 5);
      idle(2);
      // random traffic
      for (int r = 0; r < 400; r++) begin
         k = $urandom_range(99);
         if (k < 85) s = glyph[$urandom_range(15)];
         else if (k < 92) s = k[0] ? 7'b1011000 : 7'b0011000;
         else s = 7'($urandom);
         if ($urandom_range(9) < 8) sel = 3'(digs.size());
         else sel = 3'($urandom_range(7));
         if ($urandom_range(9) == 0) idle($urandom_range(1, 2));
         len = $urandom_range(1, 7);
         hold(s, sel, len);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
